ahb5_sram_subordinate: RTL and testbench

// AHB5 subordinate sitting directly downstream of the manager BFM/driver: samples the

---
 rtl/ahb5_sram_if.sv | 31 +++
 rtl/ahb5_sram_subordinate.sv | 141 ++++++++++++++
 tb/tb_ahb5_sram_subordinate.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb5_sram_if.sv
// AHB5 manager-to-subordinate signal bundle for the SRAM subordinate.
// HREADY is the bus-level ready that the interconnect feeds back to every subordinate.
interface ahb5_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  HSEL1;
  logic                  HREADY;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [STRB_WIDTH-1:0] HWSTRB;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL1, HREADY, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA, HWSTRB,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL1, HREADY, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA, HWSTRB,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb5_sram_subordinate.sv
// AHB5 subordinate backed by a flop word memory, with programmable wait states
// and the two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb5_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  ahb5_sram_if.slave  bus
);
  localparam int                  LOG2_STRB = $clog2(STRB_WIDTH);
  localparam int                  IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] BYTE_SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
  localparam logic [3:0]          WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e                 state, state_d;
  logic [3:0]             cnt, cnt_d;
  logic                   vld_p1;
  logic                   write_p1;
  logic [IDX_W-1:0]       idx_p1;
  logic [LOG2_STRB-1:0]   off_p1;
  logic [2:0]             size_p1;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic                   open_phase;
  logic                   accept;
  logic                   addr_err;
  logic                   final_cyc;
  logic [2:0]             align_mask;
  logic [STRB_WIDTH-1:0]  lane_en;
  logic                   unused_bus;

  assign unused_bus = ^{bus.HBURST, bus.HTRANS[0]};

  // ERR2 is the completing cycle of an error, so it may also take a new address.
  assign open_phase = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept     = open_phase & bus.HSEL1 & bus.HREADY & bus.HTRANS[1];
  assign final_cyc  = (state == ST_IDLE) & vld_p1;

  always_comb begin
    case (bus.HSIZE)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign addr_err = ({1'b0, bus.HADDR} >= BYTE_SPAN)
                  | (bus.HSIZE > 3'(LOG2_STRB))
                  | ((bus.HADDR[2:0] & align_mask) != 3'b000);

  // A lane belongs to the transfer when it sits in the same 2^size block as the offset.
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      lane_en[i] = ((LOG2_STRB'(i) >> size_p1) == (off_p1 >> size_p1));
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        bus.HRESP = (state == ST_ERR2);
        state_d   = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        bus.HREADYOUT = 1'b0;
        if (cnt == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
        state_d       = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address phase -> data phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      idx_p1   <= '0;
      off_p1   <= '0;
      size_p1  <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (open_phase) begin
        vld_p1 <= accept & ~addr_err;
        if (accept) begin
          write_p1 <= bus.HWRITE;
          idx_p1   <= bus.HADDR[LOG2_STRB +: IDX_W];
          off_p1   <= bus.HADDR[LOG2_STRB-1:0];
          size_p1  <= bus.HSIZE;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (final_cyc & write_p1) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (bus.HWSTRB[i] & lane_en[i]) begin
          mem[idx_p1][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign bus.HRDATA = (final_cyc & ~write_p1) ? mem[idx_p1] : '0;
endmodule

// File: tb/tb_ahb5_sram_subordinate.sv
// Scoreboard bench for ahb5_sram_subordinate: one DUT with no wait states, one with two,
// driven by a shared AHB driver and checked against a byte-array reference model.
module tb_ahb5_sram_subordinate;
  localparam int SPAN = 1024;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb5_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  ahb5_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();

  ahb5_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(b0));
  ahb5_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(b2));

  logic        act;
  logic        m_sel, m_write;
  logic [1:0]  m_trans;
  logic [2:0]  m_size, m_burst;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  logic        rdy_a, resp_a;
  logic [31:0] rdata_a;

  assign b0.HSEL1 = m_sel & ~act;   assign b2.HSEL1 = m_sel & act;
  assign b0.HREADY = b0.HREADYOUT;  assign b2.HREADY = b2.HREADYOUT;
  assign b0.HADDR = m_addr;         assign b2.HADDR = m_addr;
  assign b0.HBURST = m_burst;       assign b2.HBURST = m_burst;
  assign b0.HSIZE = m_size;         assign b2.HSIZE = m_size;
  assign b0.HTRANS = m_trans;       assign b2.HTRANS = m_trans;
  assign b0.HWRITE = m_write;       assign b2.HWRITE = m_write;
  assign b0.HWDATA = m_wdata;       assign b2.HWDATA = m_wdata;
  assign b0.HWSTRB = m_strb;        assign b2.HWSTRB = m_strb;
  assign rdy_a   = act ? b2.HREADYOUT : b0.HREADYOUT;
  assign resp_a  = act ? b2.HRESP     : b0.HRESP;
  assign rdata_a = act ? b2.HRDATA    : b0.HRDATA;

  typedef struct {
    logic        resp;
    int          waits;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          mon_waits;
  int          checks = 0;
  int          errors = 0;
  int          cur_ws;
  logic [7:0]  mdl [SPAN];
  logic [31:0] pend_wd;
  logic [3:0]  pend_st;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, want, $time);
    end
  endfunction

  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    return (a >= SPAN) || (s > 3'd2) || ((a % (32'd1 << s)) != 0);
  endfunction

  // Monitor: every negedge is one data-phase cycle of the oldest outstanding transfer.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (exp_q.size() == 0) begin
        chk("idle_ready", {63'd0, rdy_a}, 64'd1);
        chk("idle_resp", {63'd0, resp_a}, 64'd0);
      end else if (!rdy_a) begin
        mon_waits++;
        chk("wait_resp", {63'd0, resp_a}, {63'd0, exp_q[0].resp});
        if (mon_waits > 40) begin
          chk("stall", 64'(mon_waits), 64'(exp_q[0].waits));
          void'(exp_q.pop_front());
          mon_waits = 0;
        end
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp", {63'd0, resp_a}, {63'd0, mon_e.resp});
        chk("waits", 64'(mon_waits), 64'(mon_e.waits));
        chk("rdata", {32'd0, rdata_a}, {32'd0, mon_e.data});
        mon_waits = 0;
      end
    end
  end

  task automatic do_reset();
    HRESETn = 1'b0;
    exp_q.delete();
    mon_waits = 0;
    foreach (mdl[i]) mdl[i] = 8'h00;
    pend_wd = '0;  pend_st = '0;
    m_sel = 1'b0;  m_trans = 2'd0;  m_addr = '0;  m_size = 3'd0;  m_write = 1'b0;
    m_wdata = '0;  m_strb = '0;     m_burst = 3'd0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    chk("reset_ready", {63'd0, rdy_a}, 64'd1);
    chk("reset_resp", {63'd0, resp_a}, 64'd0);
    chk("reset_rdata", {32'd0, rdata_a}, 64'd0);
  endtask

  // Drives one address phase (plus the previous transfer's write data), waits for it to
  // be accepted, then pushes the model's expected data-phase response.
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st);
    exp_t e;
    int   n;
    int   lane;
    m_sel = sel;  m_trans = tr;  m_addr = a;  m_size = sz;  m_write = wr;
    m_wdata = pend_wd;  m_strb = pend_st;
    n = 0;
    @(negedge HCLK);
    while (!rdy_a && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge HCLK);
    e.resp = 1'b0;  e.waits = 0;  e.data = '0;
    if (sel && tr[1]) begin
      if (is_err(a, sz)) begin
        e.resp  = 1'b1;
        e.waits = 1;
      end else begin
        e.waits = cur_ws;
        if (wr) begin
          for (int b = 0; b < (1 << sz); b++) begin
            lane = int'(a % 4) + b;
            if (st[lane]) mdl[a + b] = wd[8*lane +: 8];
          end
        end else begin
          for (int b = 0; b < 4; b++) e.data[8*b +: 8] = mdl[(a & ~32'd3) + b];
        end
      end
    end
    exp_q.push_back(e);
    pend_wd = wd;
    pend_st = st;
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge HCLK);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_xfers(input int count);
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    int          r;
    for (int k = 0; k < count; k++) begin
      sz = 3'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 15));
      a  = (r == 0) ? 32'($urandom_range(SPAN, 4095)) : 32'($urandom_range(0, 127));
      if (r < 13) a = a & ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 9))
        0:       tr = 2'd0;
        1:       tr = 2'd1;
        default: tr = 2'($urandom_range(2, 3));
      endcase
      m_burst = 3'($urandom);
      xfer(($urandom_range(0, 9) != 0), tr, a, sz, 1'($urandom), $urandom, 4'($urandom));
    end
    m_burst = 3'd0;
  endtask

  initial begin
    act = 1'b0;
    cur_ws = 0;
    do_reset();
    xfer(1, 2'd2, 32'h10, 3'd2, 1, 32'hDEADBEEF, 4'hF);
    xfer(1, 2'd2, 32'h10, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h10, 3'd2, 1, 32'h11223344, 4'hF);
    xfer(1, 2'd2, 32'h13, 3'd0, 1, 32'hAA000000, 4'h8);
    xfer(1, 2'd2, 32'h10, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h06, 3'd1, 1, 32'hBEEF0000, 4'hC);
    xfer(1, 2'd2, 32'h04, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, SPAN, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h00, 3'd2, 1, 32'h01020304, 4'hF);
    xfer(1, 2'd2, 32'h02, 3'd2, 1, 32'hFFFFFFFF, 4'hF);
    xfer(1, 2'd2, 32'h08, 3'd2, 1, 32'h55, 4'hF);
    xfer(1, 2'd2, 32'h00, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h08, 3'd3, 1, 32'h77777777, 4'hF);
    xfer(0, 2'd2, 32'h10, 3'd2, 1, 32'h99999999, 4'hF);
    xfer(1, 2'd1, 32'h10, 3'd2, 1, 32'h88888888, 4'hF);
    xfer(1, 2'd2, 32'h10, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h08, 3'd2, 0, 32'h0, 4'h0);
    rand_xfers(150);
    xfer(1, 2'd0, 32'h0, 3'd0, 0, 32'h0, 4'h0);
    drain();

    act = 1'b1;
    cur_ws = 2;
    do_reset();
    xfer(1, 2'd2, 32'h40, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h40, 3'd2, 1, 32'hCAFEF00D, 4'hF);
    xfer(1, 2'd2, 32'h40, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, SPAN + 32'h4, 3'd2, 1, 32'h12345678, 4'hF);
    xfer(1, 2'd2, 32'h40, 3'd2, 0, 32'h0, 4'h0);
    rand_xfers(150);
    m_burst = 3'd3;
    xfer(1, 2'd2, 32'h20, 3'd2, 1, 32'hA0A0A0A0, 4'hF);
    xfer(1, 2'd3, 32'h24, 3'd2, 1, 32'hB1B1B1B1, 4'hF);
    xfer(1, 2'd3, 32'h28, 3'd2, 1, 32'hC2C2C2C2, 4'hF);
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, rdy_a}, 64'd1);
    chk("midrst_resp", {63'd0, resp_a}, 64'd0);
    chk("midrst_rdata", {32'd0, rdata_a}, 64'd0);
    do_reset();
    xfer(1, 2'd2, 32'h28, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd2, 32'h20, 3'd2, 0, 32'h0, 4'h0);
    xfer(1, 2'd0, 32'h0, 3'd0, 0, 32'h0, 4'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
